// File: rtl/ob_cmd_ingress.sv
// Byte-stream command ingress: hunts for the sync byte, assembles a 14-byte
// big-endian body, validates it and queues legal commands in a small FIFO.
package ob_pkg;

  typedef enum logic [3:0] {
    Op_Nop        = 4'h0,
    Op_Cancel     = 4'h1,
    Op_BuyLimit   = 4'h2,
    Op_SellLimit  = 4'h3,
    Op_BuyMarket  = 4'h4,
    Op_SellMarket = 4'h5,
    Op_Modify     = 4'h6
  } opcode_t;

  typedef enum logic [2:0] {
    GUC = 3'd0,
    IOC = 3'd1,
    FOK = 3'd2,
    GTD = 3'd3
  } tif_t;

  // Fields are kept as raw vectors so unchecked tif codes pass through untouched.
  typedef struct packed {
    logic [3:0]  opcode;
    logic [2:0]  tif;
    logic [31:0] uid;
    logic [19:0] price;
    logic [15:0] quantity;
    logic [31:0] uid1;
  } cmd_t;

endpackage

module ob_cmd_ingress #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         OUT_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic [7:0]   in_data,
  output logic         in_rdy,
  output logic         cmd_vld,
  output ob_pkg::cmd_t cmd,
  input  logic         cmd_rdy,
  output logic         err_vld,
  output logic [1:0]   err_code,
  output logic [15:0]  frames_ok,
  output logic [15:0]  frames_err
);

  localparam int              AW       = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int              CW       = AW + 1;
  localparam logic [CW-1:0]   FULL_CNT = CW'(OUT_DEPTH);
  localparam logic [3:0]      LAST_IDX = 4'd13;

  typedef enum logic {HUNT, BODY} state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [6:0]     b0_q, b0_d;
  logic [7:0]     body_q [1:12];
  logic [7:0]     body_d [1:12];

  ob_pkg::cmd_t   mem_q [OUT_DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  fifo_cnt_q, fifo_cnt_d;

  logic           err_vld_q, err_vld_d;
  logic [1:0]     err_code_q, err_code_d;
  logic [15:0]    frames_ok_q, frames_ok_d;
  logic [15:0]    frames_err_q, frames_err_d;

  ob_pkg::cmd_t   frame;
  logic [23:0]    price_raw;
  logic [4:0]     nib_bad;
  logic [1:0]     chk_code;
  logic           fifo_full;
  logic           pop;
  logic           accept;
  logic           last;
  logic           push;

  // The final byte is taken straight from in_data so the frame is judged
  // and pushed in the same cycle it completes.
  assign price_raw = {body_q[5], body_q[6], body_q[7]};
  assign frame = {b0_q[3:0], b0_q[6:4],
                  body_q[1], body_q[2], body_q[3], body_q[4],
                  price_raw[19:0],
                  body_q[8], body_q[9],
                  body_q[10], body_q[11], body_q[12], in_data};

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_nib
      assign nib_bad[gi] = (frame.price[gi*4 +: 4] > 4'd9);
    end
  endgenerate

  always_comb begin
    chk_code = 2'b00;
    if (frame.opcode > 4'd6) begin
      chk_code = 2'b01;
    end else if (&frame.uid) begin
      chk_code = 2'b10;
    end else if ((|nib_bad) || (|price_raw[23:20])) begin
      chk_code = 2'b11;
    end
  end

  assign cmd_vld   = (fifo_cnt_q != '0);
  assign fifo_full = (fifo_cnt_q == FULL_CNT);
  assign pop       = cmd_vld & cmd_rdy;

  // Only the closing byte can stall: a full FIFO blocks it unless the head
  // leaves in the same cycle.
  assign in_rdy = (state_q == HUNT) || !((cnt_q == LAST_IDX) && fifo_full && !cmd_rdy);
  assign accept = in_vld & in_rdy;
  assign last   = accept && (state_q == BODY) && (cnt_q == LAST_IDX);
  assign push   = last && (chk_code == 2'b00);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    b0_d    = b0_q;
    body_d  = body_q;
    if (accept) begin
      case (state_q)
        HUNT: begin
          if (in_data == SYNC_BYTE) begin
            state_d = BODY;
            cnt_d   = 4'd0;
          end
        end
        default: begin
          if (cnt_q == 4'd0) begin
            b0_d = in_data[6:0];
          end else if (cnt_q != LAST_IDX) begin
            body_d[cnt_q] = in_data;
          end
          if (cnt_q == LAST_IDX) begin
            state_d = HUNT;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      endcase
    end
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q + AW'(push);
    rd_ptr_d     = rd_ptr_q + AW'(pop);
    fifo_cnt_d   = fifo_cnt_q + CW'(push) - CW'(pop);
    err_vld_d    = last && (chk_code != 2'b00);
    err_code_d   = last ? chk_code : 2'b00;
    frames_ok_d  = frames_ok_q + 16'(push);
    frames_err_d = frames_err_q + 16'(err_vld_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= HUNT;
      cnt_q        <= 4'd0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
      err_vld_q    <= 1'b0;
      err_code_q   <= 2'b00;
      frames_ok_q  <= 16'd0;
      frames_err_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
      err_vld_q    <= err_vld_d;
      err_code_q   <= err_code_d;
      frames_ok_q  <= frames_ok_d;
      frames_err_q <= frames_err_d;
    end
  end

  // Payload storage carries no reset; its contents are only observed once
  // the control state says they are valid.
  always_ff @(posedge clk) begin
    b0_q   <= b0_d;
    body_q <= body_d;
    if (push) begin
      mem_q[wr_ptr_q] <= frame;
    end
  end

  assign cmd        = cmd_vld ? mem_q[rd_ptr_q] : '0;
  assign err_vld    = err_vld_q;
  assign err_code   = err_code_q;
  assign frames_ok  = frames_ok_q;
  assign frames_err = frames_err_q;

endmodule

// File: tb/tb_ob_cmd_ingress.sv
// Self-checking bench for ob_cmd_ingress: directed vector table, hand-written
// backpressure/reset sequences and a randomized run against a frame-level model.
module tb_ob_cmd_ingress;
  import ob_pkg::*;

  localparam logic [7:0] SYNC = 8'hA5;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_vld;
  logic [7:0]  in_data;
  logic        in_rdy;
  logic        cmd_vld;
  cmd_t        cmd;
  logic        cmd_rdy = 1'b1;
  logic        err_vld;
  logic [1:0]  err_code;
  logic [15:0] frames_ok;
  logic [15:0] frames_err;

  always #5 clk = ~clk;

  ob_cmd_ingress #(.SYNC_BYTE(SYNC), .OUT_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(in_data), .in_rdy(in_rdy),
    .cmd_vld(cmd_vld), .cmd(cmd), .cmd_rdy(cmd_rdy), .err_vld(err_vld),
    .err_code(err_code), .frames_ok(frames_ok), .frames_err(frames_err)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  cmd_t        exp_cmd_q[$];
  logic [1:0]  exp_err_q[$];
  int          model_ok = 0;
  int          model_err = 0;
  bit          mon_en = 0;
  int          rdy_mode = 1;
  bit          held = 0;
  cmd_t        held_cmd;

  typedef struct {
    logic [111:0] body;
    logic [1:0]   code;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame rules: opcode range first, then reserved uid, then BCD price.
  function automatic logic [1:0] classify(input logic [111:0] f);
    logic [3:0]  op;
    logic [31:0] uid;
    logic [23:0] pf;
    op  = f[107:104];
    uid = f[103:72];
    pf  = f[71:48];
    if (op > 4'd6) return 2'b01;
    if (uid == 32'hFFFF_FFFF) return 2'b10;
    for (int k = 0; k < 6; k++) begin
      logic [3:0] n;
      n = pf[k*4 +: 4];
      if ((k == 5) ? (n != 4'd0) : (n > 4'd9)) return 2'b11;
    end
    return 2'b00;
  endfunction

  function automatic cmd_t model_cmd(input logic [111:0] f);
    cmd_t c;
    c.opcode   = f[107:104];
    c.tif      = f[110:108];
    c.uid      = f[103:72];
    c.price    = f[67:48];
    c.quantity = f[47:32];
    c.uid1     = f[31:0];
    return c;
  endfunction

  task automatic expect_frame(input logic [111:0] f);
    logic [1:0] code;
    code = classify(f);
    if (code == 2'b00) begin
      exp_cmd_q.push_back(model_cmd(f));
      model_ok++;
    end else begin
      exp_err_q.push_back(code);
      model_err++;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit ok;
    int n;
    if (gaps) begin
      n = $urandom_range(0, 2);
      if (n > 0) begin
        in_vld = 1'b0;
        repeat (n) @(posedge clk);
        #1;
      end
    end
    in_vld  = 1'b1;
    in_data = b;
    ok = 0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (in_rdy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("in_rdy_timeout", 128'(in_rdy), 128'(1));
    @(posedge clk);
    #1;
    in_vld = 1'b0;
  endtask

  task automatic send_frame(input logic [111:0] f, input bit gaps);
    send_byte(SYNC, gaps);
    for (int i = 0; i < 14; i++) begin
      if (i == 13) expect_frame(f);
      send_byte(f[111-8*i -: 8], gaps);
    end
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (exp_cmd_q.size() == 0 && exp_err_q.size() == 0 && !cmd_vld) break;
    end
    chk("drain_cmd_left", 128'(exp_cmd_q.size()), 128'(0));
    chk("drain_err_left", 128'(exp_err_q.size()), 128'(0));
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       cmd_rdy = 1'b0;
      1:       cmd_rdy = 1'b1;
      default: cmd_rdy = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Scoreboard: every popped command and every error pulse must match the
  // next expectation in order; a stalled head must not change.
  always @(negedge clk) begin
    if (!mon_en || rst) begin
      held = 0;
    end else begin
      if (held) begin
        chk("cmd_vld_hold", 128'(cmd_vld), 128'(1));
        chk("cmd_stable", 128'(cmd), 128'(held_cmd));
      end
      if (err_vld) begin
        if (exp_err_q.size() == 0) chk("err_unexpected", 128'(err_vld), 128'(0));
        else chk("err_code", 128'(err_code), 128'(exp_err_q.pop_front()));
      end
      if (cmd_vld && cmd_rdy) begin
        if (exp_cmd_q.size() == 0) chk("cmd_unexpected", 128'(cmd_vld), 128'(0));
        else chk("cmd_content", 128'(cmd), 128'(exp_cmd_q.pop_front()));
      end
      held     = cmd_vld && !cmd_rdy;
      held_cmd = cmd;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [111:0] f031, fa, fb, fc, fd, f;
    logic [7:0]   junk;
    logic [7:0]   b0;
    logic [31:0]  uid;
    logic [19:0]  price;
    logic [3:0]   nib, hi;
    int           npass, nfail;

    rst = 1'b1; in_vld = 1'b0; in_data = 8'h00; rdy_mode = 1;
    repeat (3) @(negedge clk);
    chk("reset_cmd_vld", 128'(cmd_vld), 128'(0));
    chk("reset_err_vld", 128'(err_vld), 128'(0));
    chk("reset_err_code", 128'(err_code), 128'(0));
    chk("reset_frames_ok", 128'(frames_ok), 128'(0));
    chk("reset_frames_err", 128'(frames_err), 128'(0));
    chk("reset_cmd", 128'(cmd), 128'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    mon_en = 1;
    chk("in_rdy_after_reset", 128'(in_rdy), 128'(1));

    // Junk bytes then the reference frame; check fields one cycle after B13.
    send_byte(8'h00, 0); send_byte(8'hFF, 0); send_byte(8'h11, 0);
    f031 = 112'h02_00000007_012345_0064_00000000;
    send_frame(f031, 0);
    @(negedge clk);
    chk("ref_cmd_vld", 128'(cmd_vld), 128'(1));
    chk("ref_opcode", 128'(cmd.opcode), 128'(Op_BuyLimit));
    chk("ref_tif", 128'(cmd.tif), 128'(GUC));
    chk("ref_uid", 128'(cmd.uid), 128'(32'd7));
    chk("ref_price", 128'(cmd.price), 128'(20'h12345));
    chk("ref_quantity", 128'(cmd.quantity), 128'(16'd100));
    chk("ref_uid1", 128'(cmd.uid1), 128'(32'd0));
    chk("ref_frames_ok", 128'(frames_ok), 128'(1));
    chk("ref_err_vld", 128'(err_vld), 128'(0));
    wait_drain();
    chk("ref_frames_err", 128'(frames_err), 128'(0));

    tbl[0]  = '{112'h03_12345678_099999_FFFF_DEADBEEF, 2'd0};
    tbl[1]  = '{112'h08_00000001_000100_0001_00000002, 2'd1};
    tbl[2]  = '{112'h02_FFFFFFFF_000100_0001_00000002, 2'd2};
    tbl[3]  = '{112'h02_00000001_01A000_0001_00000002, 2'd3};
    tbl[4]  = '{112'hF6_00000010_054321_0002_00000003, 2'd0};
    tbl[5]  = '{112'h07_00000001_000001_0001_00000001, 2'd1};
    tbl[6]  = '{112'h09_FFFFFFFF_0F0000_0001_00000001, 2'd1};
    tbl[7]  = '{112'h01_FFFFFFFF_00000A_0001_00000001, 2'd2};
    tbl[8]  = '{112'h04_00000002_100000_0001_00000001, 2'd3};
    tbl[9]  = '{112'h00_A5A5A5A5_000000_A5A5_A5A5A5A5, 2'd0};
    tbl[10] = '{112'h35_00000003_00000F_0010_00000004, 2'd3};
    tbl[11] = '{112'h06_FFFFFFFE_090909_0003_00000005, 2'd0};
    npass = 0; nfail = 0;
    for (int i = 0; i < 12; i++) begin
      send_frame(tbl[i].body, 0);
      @(negedge clk);
      chk($sformatf("vec%0d_cmd_vld", i), 128'(cmd_vld), 128'(tbl[i].code == 2'd0));
      chk($sformatf("vec%0d_err_vld", i), 128'(err_vld), 128'(tbl[i].code != 2'd0));
      if (tbl[i].code != 2'd0) begin
        chk($sformatf("vec%0d_err_code", i), 128'(err_code), 128'(tbl[i].code));
        nfail++;
      end else begin
        npass++;
      end
      @(negedge clk);
      chk($sformatf("vec%0d_err_pulse_end", i), 128'(err_vld), 128'(0));
      @(posedge clk); #1;
    end
    wait_drain();
    chk("tbl_frames_ok", 128'(frames_ok), 128'(1 + npass));
    chk("tbl_frames_err", 128'(frames_err), 128'(nfail));

    // Full FIFO stalls the third frame on its last byte only.
    rdy_mode = 0;
    @(posedge clk); #1;
    fa = 112'h02_00000100_000500_0010_00000001;
    fb = 112'h03_00000200_000600_0020_00000002;
    fc = 112'h04_00000300_000700_0030_00000003;
    send_frame(fa, 0);
    send_frame(fb, 0);
    send_byte(SYNC, 0);
    for (int i = 0; i < 13; i++) send_byte(fc[111-8*i -: 8], 0);
    expect_frame(fc);
    in_vld = 1'b1; in_data = fc[7:0];
    repeat (3) begin
      @(negedge clk);
      chk("in_rdy_b13_full", 128'(in_rdy), 128'(0));
    end
    chk("stall_frames_ok", 128'(frames_ok), 128'(3 + npass));
    rdy_mode = 1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (in_rdy) break;
    end
    chk("in_rdy_release", 128'(in_rdy), 128'(1));
    @(posedge clk); #1;
    in_vld = 1'b0;
    wait_drain();
    chk("bp_frames_ok", 128'(frames_ok), 128'(4 + npass));

    // Randomized traffic with idle gaps, junk and random downstream ready.
    rdy_mode = 2;
    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(0, 2)) begin
        junk = 8'($urandom);
        while (junk == SYNC) junk = 8'($urandom);
        send_byte(junk, 1);
      end
      b0 = {1'($urandom), 3'($urandom),
            ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 6)) : 4'($urandom_range(7, 15))};
      uid = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      for (int k = 0; k < 5; k++) begin
        nib = 4'($urandom_range(0, 9));
        if ($urandom_range(0, 24) == 0) nib = 4'($urandom_range(10, 15));
        price[k*4 +: 4] = nib;
      end
      hi = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      f = {b0, uid, hi, price, 16'($urandom), 32'($urandom)};
      send_frame(f, 1);
    end
    rdy_mode = 1;
    wait_drain();
    chk("rand_frames_ok", 128'(frames_ok), 128'(16'(model_ok)));
    chk("rand_frames_err", 128'(frames_err), 128'(16'(model_err)));

    // Reset in the middle of a frame, then the tail bytes must be hunted over.
    send_byte(SYNC, 0);
    for (int i = 0; i < 7; i++) send_byte(f031[111-8*i -: 8], 0);
    mon_en = 0;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_cmd_vld", 128'(cmd_vld), 128'(0));
    chk("midrst_frames_ok", 128'(frames_ok), 128'(0));
    chk("midrst_frames_err", 128'(frames_err), 128'(0));
    chk("midrst_cmd", 128'(cmd), 128'(0));
    exp_cmd_q.delete();
    exp_err_q.delete();
    model_ok = 0; model_err = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    mon_en = 1;
    for (int i = 7; i < 14; i++) send_byte(f031[111-8*i -: 8], 0);
    fd = 112'h15_0000ABCD_098765_0200_00001234;
    send_frame(fd, 0);
    wait_drain();
    chk("post_rst_frames_ok", 128'(frames_ok), 128'(1));
    chk("post_rst_frames_err", 128'(frames_err), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ob_cmd_ingress.md
OB_CMD_INGRESS -- requirements
Module: ob_cmd_ingress

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5, frame-start delimiter.
REQ-002 SHALL have parameter OUT_DEPTH, default 2, output command FIFO entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_vld  input  1  ingress byte valid.
REQ-006 SHALL have port in_data  input  8  ingress byte.
REQ-007 SHALL have port in_rdy  output  1  ingress byte accepted when in_vld & in_rdy.
REQ-008 SHALL have port cmd_vld  output  1  assembled command valid.
REQ-009 SHALL have port cmd  output  ob_pkg::cmd_t  assembled command (107b).
REQ-010 SHALL have port cmd_rdy  input  1  downstream matching engine accepts cmd when cmd_vld & cmd_rdy.
REQ-011 SHALL have port err_vld  output  1  one-cycle pulse: frame dropped.
REQ-012 SHALL have port err_code  output  2  01 bad opcode, 10 reserved UID, 11 bad BCD price; valid with err_vld.
REQ-013 SHALL have port frames_ok  output  16  count of frames pushed to FIFO, wraps.
REQ-014 SHALL have port frames_err  output  16  count of dropped frames, wraps.

Function
REQ-015 Frame SHALL be SYNC_BYTE followed by 14 body bytes, big-endian: B0 {1'b0, tif[2:0], opcode[3:0]}; B1-B4 uid; B5-B7 {4'h0, price[19:0]}; B8-B9 quantity; B10-B13 uid1.
REQ-016 FSM SHALL have states HUNT and BODY; reset state HUNT.
REQ-017 HUNT: in_rdy=1; accepted byte == SYNC_BYTE -> BODY with byte counter=0; any other byte discarded, no error.
REQ-018 BODY: each accepted byte stored at counter position, counter increments; after B13 accepted -> HUNT.
REQ-019 In BODY, in_rdy SHALL be 1 except when counter==13 and FIFO full (no simultaneous pop), giving backpressure on the last byte only.
REQ-020 SYNC_BYTE values inside BODY SHALL be treated as data (no resync).
REQ-021 On acceptance of B13, frame SHALL be checked using B13 plus stored bytes, in priority: opcode not in 4'h0-4'h6 -> 01; uid==32'hFFFF_FFFF -> 10; any price nibble >9, or B5[7:4]!=0 -> 11.
REQ-022 Passing frame SHALL be pushed into FIFO same cycle; cmd_vld asserted next cycle (latency 1 from last byte when FIFO was empty).
REQ-023 Failing frame SHALL NOT be pushed; err_vld and err_code asserted next cycle for exactly one cycle; frames_err increments.
REQ-024 B0[7] and tif values 3'b100-3'b111 SHALL be forwarded unchecked.
REQ-025 FIFO SHALL be in order; cmd driven from head entry; cmd stable while cmd_vld & !cmd_rdy.
REQ-026 Simultaneous push and pop on a full FIFO SHALL succeed; in_rdy stays 1 on B13 in that case.
REQ-027 frames_ok SHALL increment on push, wrapping 16'hFFFF->0; frames_err likewise.
REQ-028 Op_Nop frames SHALL be forwarded like any legal opcode.

Reset
REQ-029 rst asserted SHALL immediately force HUNT, counter=0, FIFO empty, cmd_vld=0, err_vld=0, err_code=0, frames_ok=0, frames_err=0, cmd=0; in_rdy=1 after release.
REQ-030 Reset mid-frame SHALL discard the partial frame; first post-reset byte is hunted for SYNC_BYTE.

Verification
REQ-031 Send A5,02,00,00,00,07,01,23,45,00,64,00,00,00,00 with cmd_rdy=1 -> one cycle after last byte cmd_vld=1, opcode=Op_BuyLimit, tif=GUC, uid=7, price=20'h12345, quantity=100, uid1=0; frames_ok=1.
REQ-032 Send 3 junk bytes 00,FF,11 then valid frame -> junk ignored, single cmd out, no err_vld.
REQ-033 Frames with opcode 4'h8, uid FFFFFFFF, price 20'h1A000 (each otherwise valid) -> err_code 01, 10, 11 respectively, no cmd_vld, frames_err=3.
REQ-034 Hold cmd_rdy=0, send OUT_DEPTH+1 frames -> in_rdy deasserts on B13 of third frame; releasing cmd_rdy drains all three in order with unchanged contents.
REQ-035 Assert rst after B6 of a frame, then send a full frame -> only the second frame is output; counters restart from 0.
